simon_ctrl: RTL
===============

SIMON_CTRL -- requirements
Module: simon_ctrl

Interface
REQ-001 The block SHALL have parameter SHOW_TICKS, default 4: number of tick pulses the target pattern is shown in GAME.
REQ-002 The block SHALL have parameter HOLD_TICKS, default 2: number of tick pulses GOODBOY is held before returning to READY.
REQ-003 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port nrst  input  1  reset; one clock, asynchronous and active-low.
REQ-005 Port tick  input  1  single-cycle slow-time pulse from the divider.
REQ-006 Port start  input  1  single-cycle start-button event.
REQ-007 Port strobe  input  1  single-cycle keypad-press event.
REQ-008 Port key  input  4  hex value of the pressed key; valid only when strobe=1.
REQ-009 Port rnd  input  12  free-running pseudo-random value, sampled on round start.
REQ-010 Port state  output  4  game state code consumed by the display stage.
REQ-011 Port idx  output  12  three hex digits shown on the display.
REQ-012 Port count  output  4  current level shown on the display.
REQ-013 Port lsb  output  1  blink enable for the blue LED.

Function
REQ-014 State codes SHALL be RESET=1, READY=2, GAME=3, EVALUATE=4, GOODBOY=5, FAIL=6; no other code is ever driven.
REQ-015 RESET SHALL last exactly one cycle after nrst deasserts, then go to READY.
REQ-016 In READY, start=1 SHALL latch target<=rnd, clear entry and digit counter, clear tick counter, and go to GAME with phase=SHOW on the next cycle.
REQ-017 In GAME/SHOW, idx SHALL equal target and lsb SHALL be 1; each tick increments the tick counter; on the SHOW_TICKS-th tick, phase becomes ENTRY.
REQ-018 In GAME/SHOW, strobe SHALL be ignored.
REQ-019 In GAME/ENTRY, idx SHALL equal entry and lsb SHALL be 0; each strobe shifts entry <= {entry[7:0], key} and increments the 2-bit digit counter.
REQ-020 When the third digit is accepted, the block SHALL go to EVALUATE on the next cycle; idx SHALL then show the full entry.
REQ-021 EVALUATE SHALL last exactly one cycle: entry==target goes to GOODBOY, otherwise FAIL.
REQ-022 On the EVALUATE->GOODBOY transition, count SHALL increment, saturating at 4'hF.
REQ-023 GOODBOY SHALL hold for HOLD_TICKS ticks (counter cleared on entry), then go to READY.
REQ-024 FAIL SHALL hold until start=1, then set count<=1 and go to READY; it does not start a round directly.
REQ-025 start SHALL be ignored in every state except READY and FAIL; strobe SHALL be ignored outside GAME/ENTRY.
REQ-026 If tick and strobe coincide in GAME/ENTRY, the strobe SHALL be accepted; tick has no effect in ENTRY.
REQ-027 If start and strobe coincide in READY, only start SHALL act.
REQ-028 idx SHALL be 0 in RESET, READY, GOODBOY and FAIL; lsb SHALL be 0 in every state except GAME/SHOW.
REQ-029 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-030 While nrst=0, outputs SHALL immediately be state=1, idx=0, count=1, lsb=0; internal target, entry, digit and tick counters SHALL be 0, phase SHOW.
REQ-031 nrst assertion in any state, mid-round included, SHALL abandon the round and discard count.

Verification
REQ-032 Reset release, no input -> state 1 for one cycle, then 2, count=1, idx=0.
REQ-033 READY, rnd=12'h3A7, start -> state=3, idx=3A7, lsb=1; after 4 ticks lsb=0, idx=000.
REQ-034 ENTRY, keys 3,A,7 by strobe -> idx 003, 03A, 3A7; then state 4 for one cycle, 5, count=2; after 2 ticks state=2.
REQ-035 ENTRY, keys 3,A,6 -> state 4 then 6, count holds; start -> state=2, count=1.
REQ-036 Strobes in SHOW phase, start in GAME, and tick+strobe in ENTRY -> SHOW strobes ignored, start ignored, coinciding strobe accepted.
REQ-037 nrst pulsed in GAME after 2 digits, count=5 -> state=1, count=1, idx=0, lsb=0 immediately; count=4'hF with a passing round -> count stays F.

Source files
------------

// File: rtl/simon_ctrl.sv
// simon_ctrl: game controller for a "repeat the hex pattern" game.
// A round shows a random 3-digit target for SHOW_TICKS slow ticks, then
// collects three keypad digits, evaluates them and either advances the
// level (GOODBOY) or waits in FAIL for a restart.
//
// Event inputs: tick, start and strobe are single-cycle pulses with no
// back-pressure. A pulse is consumed in the cycle it is high or ignored;
// key is meaningful only in a cycle where strobe=1.
module simon_ctrl #(
  parameter int SHOW_TICKS = 4,
  parameter int HOLD_TICKS = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        tick,
  input  logic        start,
  input  logic        strobe,
  input  logic [3:0]  key,
  input  logic [11:0] rnd,
  output logic [3:0]  state,
  output logic [11:0] idx,
  output logic [3:0]  count,
  output logic        lsb
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd1,
    S_READY    = 4'd2,
    S_GAME     = 4'd3,
    S_EVALUATE = 4'd4,
    S_GOODBOY  = 4'd5,
    S_FAIL     = 4'd6
  } state_t;

  typedef enum logic {
    PH_SHOW  = 1'b0,
    PH_ENTRY = 1'b1
  } phase_t;

  // Tick counter is shared by the SHOW and GOODBOY waits.
  localparam int TMAX = (SHOW_TICKS > HOLD_TICKS) ? SHOW_TICKS : HOLD_TICKS;
  localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_TICKS - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TICKS - 1);

  state_t        st_q, st_d;
  phase_t        ph_q, ph_d;
  logic [11:0]   target_q, target_d;
  logic [11:0]   entry_q, entry_d;
  logic [1:0]    digit_q, digit_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    count_q, count_d;
  logic [11:0]   idx_q, idx_d;
  logic          lsb_q, lsb_d;

  // State code and level go straight out of their registers.
  assign state = st_q;
  assign count = count_q;
  assign idx   = idx_q;
  assign lsb   = lsb_q;

  // State register and all datapath registers, including the display outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st_q     <= S_RESET;
      ph_q     <= PH_SHOW;
      target_q <= '0;
      entry_q  <= '0;
      digit_q  <= '0;
      tcnt_q   <= '0;
      count_q  <= 4'd1;
      idx_q    <= '0;
      lsb_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      ph_q     <= ph_d;
      target_q <= target_d;
      entry_q  <= entry_d;
      digit_q  <= digit_d;
      tcnt_q   <= tcnt_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      lsb_q    <= lsb_d;
    end
  end

  // Next-state logic; display outputs are derived from the next values so
  // they line up with the state code in the same cycle.
  always_comb begin
    st_d     = st_q;
    ph_d     = ph_q;
    target_d = target_q;
    entry_d  = entry_q;
    digit_d  = digit_q;
    tcnt_d   = tcnt_q;
    count_d  = count_q;

    case (st_q)
      S_RESET: begin
        st_d = S_READY;
      end
      S_READY: begin
        // start wins over any coinciding strobe here.
        if (start) begin
          target_d = rnd;
          entry_d  = '0;
          digit_d  = '0;
          tcnt_d   = '0;
          ph_d     = PH_SHOW;
          st_d     = S_GAME;
        end
      end
      S_GAME: begin
        if (ph_q == PH_SHOW) begin
          // Keypad is dead while the target is on display.
          if (tick) begin
            tcnt_d = tcnt_q + 1'b1;
            if (tcnt_q == SHOW_LAST) begin
              ph_d = PH_ENTRY;
            end
          end
        end else begin
          // Ticks do nothing during entry, so a coinciding strobe is kept.
          if (strobe) begin
            entry_d = {entry_q[7:0], key};
            digit_d = digit_q + 2'd1;
            if (digit_q == 2'd2) begin
              st_d = S_EVALUATE;
            end
          end
        end
      end
      S_EVALUATE: begin
        if (entry_q == target_q) begin
          st_d    = S_GOODBOY;
          tcnt_d  = '0;
          count_d = (count_q == 4'hF) ? 4'hF : count_q + 4'd1;
        end else begin
          st_d = S_FAIL;
        end
      end
      S_GOODBOY: begin
        if (tick) begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_q == HOLD_LAST) begin
            st_d = S_READY;
          end
        end
      end
      S_FAIL: begin
        // Restart drops back to level 1 but does not launch a round.
        if (start) begin
          count_d = 4'd1;
          st_d    = S_READY;
        end
      end
      default: begin
        st_d = S_RESET;
      end
    endcase
  end

  // Display decode from the next state: target while showing, entry while
  // typing and evaluating, blank otherwise; LED blinks only while showing.
  always_comb begin
    idx_d = '0;
    lsb_d = 1'b0;
    if (st_d == S_GAME && ph_d == PH_SHOW) begin
      idx_d = target_d;
      lsb_d = 1'b1;
    end else if (st_d == S_GAME || st_d == S_EVALUATE) begin
      idx_d = entry_d;
    end
  end

endmodule
